ysyx_lsu_load: RTL

// - Load-issue stage directly downstream of the EXU in-order queue (IOQ); consumes the IOQ head read request.
// - Request inputs: exu_rvalid/raddr/ralu/pc. Issues one aligned 32-bit bus read.
// - Result: extracts and extends the byte/half/word and returns it to the EXU as a one-cycle exu_rready pulse.
// - On pipeline flush, discards any in-flight read; the response is drained, never forwarded.

---
 rtl/ysyx_lsu_load.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_lsu_load.sv
// Load-issue stage: takes the IOQ head load, issues one aligned bus read and returns extended data.
// Optional YSYX_LSU_MISALIGN_EN splits misaligned LH/LHU/LW into two aligned reads.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_ALU_LB__
`define YSYX_ALU_LB__ 5'h10
`endif
`ifndef YSYX_ALU_LH__
`define YSYX_ALU_LH__ 5'h11
`endif
`ifndef YSYX_ALU_LW__
`define YSYX_ALU_LW__ 5'h12
`endif
`ifndef YSYX_ALU_LBU_
`define YSYX_ALU_LBU_ 5'h14
`endif
`ifndef YSYX_ALU_LHU_
`define YSYX_ALU_LHU_ 5'h15
`endif

module ysyx_lsu_load #(
  parameter int XLEN = `YSYX_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipe,
  input  logic            exu_rvalid,
  input  logic [XLEN-1:0] exu_raddr,
  input  logic [4:0]      exu_ralu,
  input  logic [XLEN-1:0] exu_pc,
  output logic            exu_rready,
  output logic [XLEN-1:0] exu_rdata,
  output logic            exu_rerr,
  output logic [XLEN-1:0] exu_fault_pc,
  output logic            bus_arvalid,
  output logic [XLEN-1:0] bus_araddr,
  input  logic            bus_arready,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic [1:0]      bus_rresp
);

  localparam int SHW = $clog2(2 * XLEN);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
`ifdef YSYX_LSU_MISALIGN_EN
  localparam logic [2:0] REQ2  = 3'd5;
  localparam logic [2:0] WAIT2 = 3'd6;
`endif

  logic [2:0]        state;
  logic [XLEN-1:0]   addr_q;
  logic [4:0]        ralu_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   word_base;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   lane_data;
  logic [XLEN-1:0]   ext_data;

  function automatic logic is_misaligned(input logic [4:0] alu, input logic [1:0] lane);
    case (alu)
      `YSYX_ALU_LH__, `YSYX_ALU_LHU_: return lane[0];
      `YSYX_ALU_LW__:                 return lane != 2'b00;
      default:                        return 1'b0;
    endcase
  endfunction

`ifdef YSYX_LSU_MISALIGN_EN
  logic [XLEN-1:0] w0_q;
  logic            err0_q;
  logic            misal_q;
  assign misal_q = is_misaligned(ralu_q, addr_q[1:0]);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      ralu_q <= '0;
      pc_q   <= '0;
`ifdef YSYX_LSU_MISALIGN_EN
      w0_q   <= '0;
      err0_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (exu_rvalid && !flush_pipe) begin
          addr_q <= exu_raddr;
          ralu_q <= exu_ralu;
          pc_q   <= exu_pc;
`ifdef YSYX_LSU_MISALIGN_EN
          state  <= REQ;
`else
          state  <= is_misaligned(exu_ralu, exu_raddr[1:0]) ? RESP : REQ;
`endif
        end
        REQ: begin
          if (flush_pipe)       state <= bus_arready ? DRAIN : IDLE;
          else if (bus_arready) state <= WAIT;
        end
        WAIT: begin
          if (flush_pipe) state <= bus_rvalid ? IDLE : DRAIN;
          else if (bus_rvalid) begin
`ifdef YSYX_LSU_MISALIGN_EN
            if (misal_q) begin
              state  <= REQ2;
              w0_q   <= bus_rdata;
              err0_q <= bus_rresp != 2'b00;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
`ifdef YSYX_LSU_MISALIGN_EN
        REQ2: begin
          if (flush_pipe)       state <= bus_arready ? DRAIN : IDLE;
          else if (bus_arready) state <= WAIT2;
        end
        WAIT2: begin
          if (flush_pipe)      state <= bus_rvalid ? IDLE : DRAIN;
          else if (bus_rvalid) state <= IDLE;
        end
`endif
        RESP:    state <= IDLE;
        DRAIN:   if (bus_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    word_base   = {addr_q[XLEN-1:2], 2'b00};
    bus_arvalid = (state == REQ);
    bus_araddr  = word_base;
    merged      = {{XLEN{1'b0}}, bus_rdata};
`ifdef YSYX_LSU_MISALIGN_EN
    // second beat reads the following word; the sum wraps at the top of the address space
    if (state == REQ2) begin
      bus_arvalid = 1'b1;
      bus_araddr  = word_base + XLEN'(4);
    end
    if (state == WAIT2) merged = {bus_rdata, w0_q};
`endif
    lane_data = merged[SHW'({addr_q[1:0], 3'b000}) +: XLEN];
    case (ralu_q)
      `YSYX_ALU_LB__: ext_data = {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
      `YSYX_ALU_LBU_: ext_data = {{(XLEN-8){1'b0}}, lane_data[7:0]};
      `YSYX_ALU_LH__: ext_data = {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
      `YSYX_ALU_LHU_: ext_data = {{(XLEN-16){1'b0}}, lane_data[15:0]};
      default:        ext_data = lane_data;
    endcase

    exu_rready = 1'b0;
    exu_rerr   = 1'b0;
    case (state)
      WAIT: begin
        exu_rready = bus_rvalid && !flush_pipe;
`ifdef YSYX_LSU_MISALIGN_EN
        if (misal_q) exu_rready = 1'b0;
`endif
        exu_rerr = exu_rready && (bus_rresp != 2'b00);
      end
`ifdef YSYX_LSU_MISALIGN_EN
      WAIT2: begin
        exu_rready = bus_rvalid && !flush_pipe;
        exu_rerr   = exu_rready && (err0_q || (bus_rresp != 2'b00));
      end
`endif
      RESP: begin
        exu_rready = !flush_pipe;
        exu_rerr   = exu_rready;
      end
      default: ;
    endcase
    exu_rdata = (exu_rready && !exu_rerr) ? ext_data : '0;
  end

  assign exu_fault_pc = pc_q;

endmodule
